// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, host command bytes
// and the default end-of-program marker.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLdRst,
    StLoad,
    StRunRst,
    StRun,
    StStRst,
    StStep
  } state_e;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_EXIT = 8'h45;

  localparam logic [31:0] END_MARKER_DFLT = 32'hFFFF_FFFF;

endpackage

// File: rtl/word_assembler.sv
// Packs an MSB-first byte stream into words; flags the cycle in which the last byte
// of a word arrives and presents the complete word alongside it.
module word_assembler #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_byte_valid,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic               o_word_valid,
  output logic [NB_DATA-1:0] o_word
);

  localparam int unsigned NB_PER_WORD = NB_DATA / NB_BYTE;
  localparam int unsigned NB_IDX      = (NB_PER_WORD > 1) ? $clog2(NB_PER_WORD) : 1;
  localparam logic [NB_IDX-1:0] IDX_LAST = NB_IDX'(NB_PER_WORD - 1);

  // Only the leading bytes are stored; the final byte is taken straight from the input.
  logic [NB_DATA-NB_BYTE-1:0] r_shift;
  logic [NB_IDX-1:0]          r_idx;
  logic                       w_take;

  assign w_take = i_en && i_byte_valid;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_take) begin
      r_shift <= {r_shift[NB_DATA-2*NB_BYTE-1:0], i_byte};
      r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + NB_IDX'(1);
    end
  end

  assign o_word_valid = w_take && (r_idx == IDX_LAST);
  assign o_word       = {r_shift, i_byte};

endmodule

// File: rtl/prog_loader.sv
// Host front end for the MIPS pipeline: loads IMEM from a UART byte stream, then
// drives pipeline reset and halt for free run (with watchdog) or single-step.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned         NB_DATA    = 32,
  parameter int unsigned         NB_BYTE    = 8,
  parameter int unsigned         IMEM_DEPTH = 64,
  parameter int unsigned         NB_CNT     = 7,
  parameter logic [NB_DATA-1:0]  END_MARKER = END_MARKER_DFLT,
  parameter int unsigned         RST_CYCLES = 2,
  parameter int unsigned         MAX_CYCLES = 1024,
  parameter int unsigned         NB_WDOG    = 11
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_rx_valid,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_pipe_done,
  output logic               o_rst_n_pipe,
  output logic               o_we_IF,
  output logic [NB_DATA-1:0] o_instruction_data,
  output logic               o_halt,
  output logic [NB_CNT-1:0]  o_prog_len,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic               o_timeout
);

  localparam int unsigned NB_RST = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [NB_RST-1:0]  RST_LAST  = NB_RST'(RST_CYCLES - 1);
  localparam logic [NB_CNT-1:0]  CNT_FULL  = NB_CNT'(IMEM_DEPTH);
  localparam logic [NB_WDOG-1:0] WDOG_LAST = NB_WDOG'(MAX_CYCLES - 1);

  state_e               r_state, w_state_d;
  logic [NB_RST-1:0]    r_rst_cnt, w_rst_cnt_d;
  logic [NB_CNT-1:0]    r_cnt, w_cnt_d;
  logic [NB_WDOG-1:0]   r_wdog, w_wdog_d;
  logic                 r_rst_n_pipe, w_rst_n_pipe_d;
  logic                 r_halt, w_halt_d;
  logic                 r_we, w_we_d;
  logic [NB_DATA-1:0]   r_instr, w_instr_d;
  logic [NB_CNT-1:0]    r_prog_len, w_prog_len_d;
  logic                 r_busy, w_busy_d;
  logic                 r_done, w_done_d;
  logic                 r_error, w_error_d;
  logic                 r_timeout, w_timeout_d;
  logic                 w_step;
  logic                 w_asm_clr;
  logic                 w_asm_en;
  logic                 w_word_valid;
  logic [NB_DATA-1:0]   w_word;

  assign w_asm_clr = (r_state == StLdRst);
  assign w_asm_en  = (r_state == StLoad);

  word_assembler #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_word_assembler (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_clr        (w_asm_clr),
    .i_en         (w_asm_en),
    .i_byte_valid (i_rx_valid),
    .i_byte       (i_rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_comb begin
    w_state_d    = r_state;
    w_rst_cnt_d  = r_rst_cnt;
    w_cnt_d      = r_cnt;
    w_wdog_d     = r_wdog;
    w_we_d       = 1'b0;
    w_instr_d    = r_instr;
    w_prog_len_d = r_prog_len;
    w_done_d     = 1'b0;
    w_error_d    = r_error;
    w_timeout_d  = r_timeout;
    w_step       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) begin
            w_state_d    = StLdRst;
            w_rst_cnt_d  = '0;
            w_cnt_d      = '0;
            w_error_d    = 1'b0;
            w_prog_len_d = '0;
          end else if (i_rx_data == CMD_RUN) begin
            w_state_d   = StRunRst;
            w_rst_cnt_d = '0;
            w_wdog_d    = '0;
            w_timeout_d = 1'b0;
          end else if (i_rx_data == CMD_STEP) begin
            w_state_d   = StStRst;
            w_rst_cnt_d = '0;
            w_wdog_d    = '0;
            w_timeout_d = 1'b0;
          end
        end
      end
      StLdRst, StRunRst, StStRst: begin
        if (r_rst_cnt == RST_LAST) begin
          if (r_state == StLdRst)       w_state_d = StLoad;
          else if (r_state == StRunRst) w_state_d = StRun;
          else                          w_state_d = StStep;
        end else begin
          w_rst_cnt_d = r_rst_cnt + NB_RST'(1);
        end
      end
      StLoad: begin
        if (w_word_valid) begin
          if (w_word == END_MARKER) begin
            w_prog_len_d = r_cnt;
            w_state_d    = StIdle;
          end else if (r_cnt == CNT_FULL) begin
            w_error_d    = 1'b1;
            w_prog_len_d = r_cnt;
            w_state_d    = StIdle;
          end else begin
            w_we_d    = 1'b1;
            w_instr_d = w_word;
            w_cnt_d   = r_cnt + NB_CNT'(1);
          end
        end
      end
      StRun: begin
        // Completion takes priority over a watchdog expiring in the same cycle.
        if (i_pipe_done) begin
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end else if (r_wdog == WDOG_LAST) begin
          w_timeout_d = 1'b1;
          w_done_d    = 1'b1;
          w_state_d   = StIdle;
        end else begin
          w_wdog_d = r_wdog + NB_WDOG'(1);
        end
      end
      StStep: begin
        // r_halt low marks the single cycle the pipeline is actually advancing.
        if ((!r_halt && i_pipe_done) || (i_rx_valid && i_rx_data == CMD_EXIT)) begin
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end else if (i_rx_valid && i_rx_data == CMD_STEP) begin
          w_step = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    w_rst_n_pipe_d = !((w_state_d == StLdRst) || (w_state_d == StRunRst) ||
                       (w_state_d == StStRst));
    w_halt_d       = !((w_state_d == StRun) || w_step);
    w_busy_d       = (w_state_d != StIdle);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_rst_cnt    <= '0;
      r_cnt        <= '0;
      r_wdog       <= '0;
      r_rst_n_pipe <= 1'b0;
      r_halt       <= 1'b1;
      r_we         <= 1'b0;
      r_instr      <= '0;
      r_prog_len   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_rst_cnt    <= w_rst_cnt_d;
      r_cnt        <= w_cnt_d;
      r_wdog       <= w_wdog_d;
      r_rst_n_pipe <= w_rst_n_pipe_d;
      r_halt       <= w_halt_d;
      r_we         <= w_we_d;
      r_instr      <= w_instr_d;
      r_prog_len   <= w_prog_len_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_error      <= w_error_d;
      r_timeout    <= w_timeout_d;
    end
  end

  assign o_rst_n_pipe       = r_rst_n_pipe;
  assign o_we_IF            = r_we;
  assign o_instruction_data = r_instr;
  assign o_halt             = r_halt;
  assign o_prog_len         = r_prog_len;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_error            = r_error;
  assign o_timeout          = r_timeout;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader: expected IMEM writes are queued by the stimulus and
// popped by an independent monitor; session outcomes come from a behavioural model.
module tb_prog_loader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXC  = 16;
  localparam logic [31:0] MARK  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        pipe_done;
  logic        o_rst_n_pipe, o_we_IF, o_halt, o_busy, o_done, o_error, o_timeout;
  logic [31:0] o_instruction_data;
  logic [6:0]  o_prog_len;

  prog_loader #(
    .IMEM_DEPTH (DEPTH),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk                (clk),
    .i_rst_n            (rst_n),
    .i_rx_valid         (rx_valid),
    .i_rx_data          (rx_data),
    .i_pipe_done        (pipe_done),
    .o_rst_n_pipe       (o_rst_n_pipe),
    .o_we_IF            (o_we_IF),
    .o_instruction_data (o_instruction_data),
    .o_halt             (o_halt),
    .o_prog_len         (o_prog_len),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_error            (o_error),
    .o_timeout          (o_timeout)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];
  int mon_writes = 0, mon_done = 0, mon_halt_low = 0, mon_rst_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every IMEM write.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!o_rst_n_pipe) mon_rst_low++;
        if (!o_halt)       mon_halt_low++;
        if (o_done)        mon_done++;
        if (o_we_IF) begin
          mon_writes++;
          if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_write: got %0h want no write", o_instruction_data);
          end else begin
            check("imem_write", o_instruction_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timed out");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rst_n_pipe"}, 32'(o_rst_n_pipe), 0);
    check({tag, "_halt"},       32'(o_halt), 1);
    check({tag, "_we"},         32'(o_we_IF), 0);
    check({tag, "_instr"},      o_instruction_data, 0);
    check({tag, "_prog_len"},   32'(o_prog_len), 0);
    check({tag, "_busy"},       32'(o_busy), 0);
    check({tag, "_done"},       32'(o_done), 0);
    check({tag, "_error"},      32'(o_error), 0);
    check({tag, "_timeout"},    32'(o_timeout), 0);
  endtask

  // Model: words are written in order until the marker or until IMEM is full.
  task automatic do_load(input logic [31:0] words[$], input int gap_max);
    int rb, wb, cnt, stop;
    logic err;
    logic [31:0] w;
    rb = mon_rst_low;
    wb = mon_writes;
    send_byte(8'h4C);
    idle(4);
    check("ld_rst_len", 32'(mon_rst_low - rb), 2);
    check("ld_err_clr", 32'(o_error), 0);
    check("ld_busy", 32'(o_busy), 1);
    cnt  = 0;
    err  = 1'b0;
    stop = words.size() - 1;
    for (int i = 0; i < words.size(); i++) begin
      if (words[i] == MARK) begin
        stop = i;
        break;
      end
      if (cnt == DEPTH) begin
        err  = 1'b1;
        stop = i;
        break;
      end
      exp_q.push_back(words[i]);
      cnt++;
    end
    for (int i = 0; i <= stop; i++) begin
      w = words[i];
      for (int k = 3; k >= 0; k--) begin
        send_byte(w[8*k +: 8]);
        idle($urandom_range(gap_max, 0));
      end
    end
    idle(4);
    check("ld_writes", 32'(mon_writes - wb), 32'(cnt));
    check("ld_sb_empty", 32'(exp_q.size()), 0);
    check("ld_prog_len", 32'(o_prog_len), 32'(cnt));
    check("ld_error", 32'(err), 32'(o_error));
    check("ld_busy_end", 32'(o_busy), 0);
  endtask

  // Model: halt releases two cycles after the command; a done observed after n cycles
  // gives n-1 run cycles, capped by the watchdog (which loses a tie).
  task automatic do_run(input int n, input bit with_done);
    int rb, hb, db, run_cyc, exp_low;
    bit exp_to;
    rb = mon_rst_low;
    hb = mon_halt_low;
    db = mon_done;
    send_byte(8'h52);
    if (with_done) begin
      idle(n);
      pipe_done = 1'b1;
      idle(1);
      pipe_done = 1'b0;
    end
    idle(24);
    run_cyc = with_done ? n - 1 : 1000;
    exp_low = (run_cyc < MAXC) ? run_cyc : MAXC;
    exp_to  = (run_cyc > MAXC);
    check("run_rst_len", 32'(mon_rst_low - rb), 2);
    check("run_halt_low", 32'(mon_halt_low - hb), 32'(exp_low));
    check("run_done_cnt", 32'(mon_done - db), 1);
    check("run_timeout", 32'(o_timeout), 32'(exp_to));
    check("run_busy_end", 32'(o_busy), 0);
    check("run_halt_end", 32'(o_halt), 1);
  endtask

  task automatic do_step(input int n_steps, input bit exit_by_done);
    int rb, hb, db;
    logic [7:0] b;
    rb = mon_rst_low;
    hb = mon_halt_low;
    db = mon_done;
    send_byte(8'h53);
    idle(4);
    check("st_rst_len", 32'(mon_rst_low - rb), 2);
    for (int i = 0; i < n_steps; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        do b = 8'($urandom_range(255, 0)); while (b == 8'h45 || b == 8'h53);
        send_byte(b);
        pipe_done = 1'b1;
        idle(1);
        pipe_done = 1'b0;
      end
      send_byte(8'h53);
      if (exit_by_done && i == n_steps - 1) pipe_done = 1'b1;
      idle(1);
      pipe_done = 1'b0;
      idle($urandom_range(2, 0));
    end
    if (!exit_by_done) begin
      check("st_busy_pre_exit", 32'(o_busy), 1);
      send_byte(8'h45);
    end
    idle(3);
    check("st_halt_low", 32'(mon_halt_low - hb), 32'(n_steps));
    check("st_done_cnt", 32'(mon_done - db), 1);
    check("st_busy_end", 32'(o_busy), 0);
  endtask

  initial begin
    logic [31:0] wq[$];
    logic [31:0] w;
    int rb, db;
    logic [7:0] b;
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    pipe_done = 1'b0;
    idle(3);
    check_reset_vals("por");
    rst_n = 1'b1;
    idle(2);

    wq = {};
    wq.push_back(32'h2001000F);
    wq.push_back(32'hA0010000);
    wq.push_back(MARK);
    do_load(wq, 0);

    wq = {};
    for (int i = 0; i < 5; i++) wq.push_back($urandom() & 32'h7FFF_FFFF);
    wq.push_back(MARK);
    do_load(wq, 1);
    wq = {};
    wq.push_back(MARK);
    do_load(wq, 0);

    for (int t = 0; t < 6; t++) begin
      wq = {};
      for (int i = 0; i < int'($urandom_range(6, 0)); i++) begin
        w = $urandom();
        if (w == MARK) w = 32'h0;
        wq.push_back(w);
      end
      wq.push_back(MARK);
      do_load(wq, 1);
    end

    do_run(12, 1'b1);
    do_run(17, 1'b1);
    do_run(18, 1'b1);
    do_run(3, 1'b1);
    do_run(0, 1'b0);
    do_run(12, 1'b1);
    for (int t = 0; t < 4; t++) do_run(int'($urandom_range(25, 3)), 1'b1);

    do_step(2, 1'b0);
    do_step(3, 1'b1);
    do_step(0, 1'b0);
    for (int t = 0; t < 3; t++) do_step(int'($urandom_range(4, 1)), 1'($urandom_range(1, 0)));

    rb = mon_rst_low;
    db = mon_done;
    for (int i = 0; i < 8; i++) begin
      do b = 8'($urandom_range(255, 0)); while (b == 8'h4C || b == 8'h52 || b == 8'h53);
      send_byte(b);
    end
    idle(2);
    check("idle_busy", 32'(o_busy), 0);
    check("idle_rst_low", 32'(mon_rst_low - rb), 0);
    check("idle_done", 32'(mon_done - db), 0);

    send_byte(8'h4C);
    idle(4);
    send_byte(8'h20);
    send_byte(8'h01);
    rst_n = 1'b0;
    #2;
    check_reset_vals("mid");
    idle(2);
    rst_n = 1'b1;
    idle(2);
    wq = {};
    wq.push_back(32'h2001000F);
    wq.push_back(MARK);
    do_load(wq, 0);

    check("final_sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
